// File: rtl/led_scan_sequencer.sv
// led_scan_sequencer: column scanner for an N x N LED grid (Conway display).
// Each column is blanked for BLANK_TICKS cycles and then driven for
// DWELL_TICKS cycles. A one-entry shadow buffer accepts new frames at any time.
// Frames are swapped into cells_out only at the end of a full sweep, or while
// idle, so a sweep never shows two different frames.
// Optional feature: define LED_SCAN_BLANK_EN to enable the BLANK phase.
// Without it, columns are driven back to back and BLANK_TICKS is ignored.
module led_scan_sequencer #(
   parameter int N           = 8,
   parameter int DWELL_TICKS = 1000,
   parameter int BLANK_TICKS = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic [N*N-1:0]        cells_in,
   input  logic                  cells_valid,
   output logic                  cells_ready,
   output logic [N*N-1:0]        cells_out,
   output logic [$clog2(N):0]    x,
   output logic                  led_ena,
   output logic                  frame_done
);

   localparam int XW   = $clog2(N) + 1;
   localparam int MAXT = (DWELL_TICKS > BLANK_TICKS) ? DWELL_TICKS : BLANK_TICKS;
   localparam int CW   = $clog2(MAXT + 1);
   localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_TICKS - 1);
`ifdef LED_SCAN_BLANK_EN
   localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_TICKS - 1);
`endif

   // Reject illegal geometry or timing when the design is elaborated
   if (N < 1 || N > 8 || DWELL_TICKS < 1 || BLANK_TICKS < 1) begin : g_param_check
      $error("led_scan_sequencer: N must be 1..8 and DWELL_TICKS/BLANK_TICKS at least 1");
   end

`ifdef LED_SCAN_BLANK_EN
   typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, DRIVE = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd2} state_t;
`endif

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XW-1:0]   x_q, x_d;
   logic            led_ena_q, led_ena_d;
   logic            frame_done_q, frame_done_d;
   logic [N*N-1:0]  shadow_q, shadow_d;
   logic            cells_ready_q, cells_ready_d;
   logic [N*N-1:0]  cells_out_q, cells_out_d;
   logic            col_end;
   logic            frame_end;

   // Dwell counter reaching zero in DRIVE marks a column end; the last column ends the frame
   always_comb begin
      col_end   = (state_q == DRIVE) && (cnt_q == '0);
      frame_end = ena && col_end && (x_q == XW'(N - 1));
   end

   // Scan FSM: next state, column index, dwell/blank counter and registered drive outputs
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      x_d          = x_q;
      led_ena_d    = led_ena_q;
      frame_done_d = 1'b0;
      if (!ena) begin
         state_d   = IDLE;
         cnt_d     = '0;
         x_d       = '0;
         led_ena_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               x_d = '0;
`ifdef LED_SCAN_BLANK_EN
               state_d   = BLANK;
               cnt_d     = BLANK_LOAD;
               led_ena_d = 1'b0;
`else
               state_d   = DRIVE;
               cnt_d     = DWELL_LOAD;
               led_ena_d = 1'b1;
`endif
            end
`ifdef LED_SCAN_BLANK_EN
            BLANK: begin
               if (cnt_q == '0) begin
                  state_d   = DRIVE;
                  cnt_d     = DWELL_LOAD;
                  led_ena_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
`endif
            DRIVE: begin
               if (col_end) begin
                  if (x_q == XW'(N - 1)) begin
                     x_d          = '0;
                     frame_done_d = 1'b1;
                  end else begin
                     x_d = x_q + XW'(1);
                  end
`ifdef LED_SCAN_BLANK_EN
                  state_d   = BLANK;
                  cnt_d     = BLANK_LOAD;
                  led_ena_d = 1'b0;
`else
                  state_d   = DRIVE;
                  cnt_d     = DWELL_LOAD;
                  led_ena_d = 1'b1;
`endif
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            default: begin
               state_d   = IDLE;
               cnt_d     = '0;
               x_d       = '0;
               led_ena_d = 1'b0;
            end
         endcase
      end
   end

   // Shadow buffer: accept a frame when empty, swap it out at frame end or while idle
   always_comb begin
      shadow_d      = shadow_q;
      cells_ready_d = cells_ready_q;
      cells_out_d   = cells_out_q;
      if (cells_ready_q && cells_valid) begin
         shadow_d      = cells_in;
         cells_ready_d = 1'b0;
      end else if (!cells_ready_q && (frame_end || state_q == IDLE)) begin
         cells_out_d   = shadow_q;
         cells_ready_d = 1'b1;
      end
   end

   // State register with asynchronous reset to an idle, empty, dark display
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         x_q           <= '0;
         led_ena_q     <= 1'b0;
         frame_done_q  <= 1'b0;
         shadow_q      <= '0;
         cells_ready_q <= 1'b1;
         cells_out_q   <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         x_q           <= x_d;
         led_ena_q     <= led_ena_d;
         frame_done_q  <= frame_done_d;
         shadow_q      <= shadow_d;
         cells_ready_q <= cells_ready_d;
         cells_out_q   <= cells_out_d;
      end
   end

   // Every output comes straight from a flop
   always_comb begin
      x           = x_q;
      led_ena     = led_ena_q;
      frame_done  = frame_done_q;
      cells_ready = cells_ready_q;
      cells_out   = cells_out_q;
   end

endmodule

// File: tb/tb_led_scan_sequencer.sv
// tb_led_scan_sequencer: directed bench for led_scan_sequencer with N=8,
// DWELL_TICKS=4, BLANK_TICKS=2. Expectations follow LED_SCAN_BLANK_EN
// (blank phase present or absent) when it is defined for the whole build.
module tb_led_scan_sequencer;

   localparam int N     = 8;
   localparam int DWELL = 4;
   localparam int BLANK = 2;
`ifdef LED_SCAN_BLANK_EN
   localparam int BT = BLANK;
`else
   localparam int BT = 0;
`endif
   localparam int P = BT + DWELL;
   localparam int F = N * P;

   localparam logic [63:0] FRAME0 = 64'h0000_0000_0000_FF00;
   localparam logic [63:0] FRAMEA = 64'h00A5_A5A5_3C3C_0081;
   localparam logic [63:0] FRAMEB = 64'h5A5A_0000_C3C3_7E00;

   logic          clk = 1'b0;
   logic          rst;
   logic          ena;
   logic [63:0]   cellsIn;
   logic          cellsValid;
   logic          cellsReady;
   logic [63:0]   cellsOut;
   logic [3:0]    x;
   logic          ledEna;
   logic          frameDone;

   int compared   = 0;
   int mismatched = 0;

   led_scan_sequencer #(
      .N(N),
      .DWELL_TICKS(DWELL),
      .BLANK_TICKS(BLANK)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ena(ena),
      .cells_in(cellsIn),
      .cells_valid(cellsValid),
      .cells_ready(cellsReady),
      .cells_out(cellsOut),
      .x(x),
      .led_ena(ledEna),
      .frame_done(frameDone)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Drive all DUT inputs at once
   task automatic applyStimulus(input logic enaV, input logic validV, input logic [63:0] dataV);
      ena        = enaV;
      cellsValid = validV;
      cellsIn    = dataV;
   endtask

   // Compare one observed value against its expected value
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance one rising edge and sample just after it
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Expected displayed frame after edge k of the first long run
   function automatic logic [63:0] expOut(int k);
      if (k >= 3 * F) return FRAMEB;
      if (k >= 2 * F) return FRAMEA;
      if (k >= F) return FRAME0;
      return 64'h0;
   endfunction

   // Expected cells_ready after edge k of the first long run
   function automatic logic expReady(int k);
      if (k >= 10 && k < F) return 1'b0;
      if (k >= F + 5 && k < 2 * F) return 1'b0;
      if (k >= 2 * F + 1 && k < 3 * F) return 1'b0;
      return 1'b1;
   endfunction

   // Directed sequence: reset, sweeps with frame loads, disable, restart, async reset
   initial begin
      int kEnd;
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 64'h0);
      #22;
      checkOutput("reset_x", {60'h0, x}, 64'h0);
      checkOutput("reset_led_ena", {63'h0, ledEna}, 64'h0);
      checkOutput("reset_frame_done", {63'h0, frameDone}, 64'h0);
      checkOutput("reset_cells_out", cellsOut, 64'h0);
      checkOutput("reset_cells_ready", {63'h0, cellsReady}, 64'h1);

      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 64'h0);

      kEnd = 3 * F + 3 * P + BT + 1;
      for (int k = 0; k <= kEnd; k++) begin
         stepCycle();
         checkOutput($sformatf("sweep_led_ena k=%0d", k), {63'h0, ledEna}, {63'h0, ((k % P) >= BT)});
         checkOutput($sformatf("sweep_x k=%0d", k), {60'h0, x}, 64'((k / P) % N));
         checkOutput($sformatf("sweep_frame_done k=%0d", k), {63'h0, frameDone},
                     {63'h0, (k > 0 && (k % F) == 0)});
         checkOutput($sformatf("sweep_cells_ready k=%0d", k), {63'h0, cellsReady}, {63'h0, expReady(k)});
         checkOutput($sformatf("sweep_cells_out k=%0d", k), cellsOut, expOut(k));
         if (k == 9)          applyStimulus(1'b1, 1'b1, FRAME0);
         if (k == 10)         applyStimulus(1'b1, 1'b0, 64'h0);
         if (k == F + 4)      applyStimulus(1'b1, 1'b1, FRAMEA);
         if (k == F + 5)      applyStimulus(1'b1, 1'b1, FRAMEB);
         if (k == 2 * F + 1)  applyStimulus(1'b1, 1'b0, 64'h0);
      end

      $display("[TB] dropping ena during DRIVE at column 3");
      applyStimulus(1'b0, 1'b0, 64'h0);
      for (int i = 0; i < 3; i++) begin
         stepCycle();
         checkOutput($sformatf("disable_led_ena i=%0d", i), {63'h0, ledEna}, 64'h0);
         checkOutput($sformatf("disable_x i=%0d", i), {60'h0, x}, 64'h0);
         checkOutput($sformatf("disable_frame_done i=%0d", i), {63'h0, frameDone}, 64'h0);
         checkOutput($sformatf("disable_cells_out i=%0d", i), cellsOut, FRAMEB);
         checkOutput($sformatf("disable_cells_ready i=%0d", i), {63'h0, cellsReady}, 64'h1);
      end

      applyStimulus(1'b1, 1'b0, 64'h0);
      for (int j = 0; j <= P + BT + 1; j++) begin
         stepCycle();
         checkOutput($sformatf("restart_led_ena j=%0d", j), {63'h0, ledEna}, {63'h0, ((j % P) >= BT)});
         checkOutput($sformatf("restart_x j=%0d", j), {60'h0, x}, 64'(j / P));
         checkOutput($sformatf("restart_frame_done j=%0d", j), {63'h0, frameDone}, 64'h0);
      end

      $display("[TB] asserting rst between clock edges during DRIVE");
      #3;
      rst = 1'b1;
      #1;
      checkOutput("async_x", {60'h0, x}, 64'h0);
      checkOutput("async_led_ena", {63'h0, ledEna}, 64'h0);
      checkOutput("async_frame_done", {63'h0, frameDone}, 64'h0);
      checkOutput("async_cells_out", cellsOut, 64'h0);
      checkOutput("async_cells_ready", {63'h0, cellsReady}, 64'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
